// File: rtl/seg_scan_n.sv
// seg_scan_n: multiplexed 7-segment scanner, N common-anode digits.
// Frame-synchronous loading, leading-zero blanking, anti-ghost blank.
//
// Ports:
//   clk, reset_n      system clock, async active-low reset
//   value_i           packed hex nibbles, digit k = value_i[4k+3:4k]
//   dp_i              per-digit decimal point request (active high)
//   load_i            one-cycle strobe capturing value_i/dp_i
//   lz_blank_i        leading-zero blanking enable (live)
//   blink_mask_i      digits to blink (only with SEG_SCAN_BLINK_EN)
//   seg_o             active-low segments {a,b,c,d,e,f,g,dp}
//   sel_o             active-low one-hot digit select
//   frame_done_o      one-cycle pulse after each full scan
//
// Optional feature: define SEG_SCAN_BLINK_EN for per-digit blinking.

module seg_scan_n #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 100000,
    parameter int BLANK_CYCLES = 1000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [4*DIGITS-1:0] value_i,
    input  logic [DIGITS-1:0]   dp_i,
    input  logic                load_i,
    input  logic                lz_blank_i,
`ifdef SEG_SCAN_BLINK_EN
    input  logic [DIGITS-1:0]   blink_mask_i,
`endif
    output logic [7:0]          seg_o,
    output logic [DIGITS-1:0]   sel_o,
    output logic                frame_done_o
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_END = SW'(BLANK_CYCLES);
    localparam logic [DW-1:0] DIG_LAST  = DW'(DIGITS - 1);

    if (DIGITS < 1 || DIGITS > 8 || SCAN_DIV < 2 ||
        BLANK_CYCLES >= SCAN_DIV || BLINK_FRAMES < 1) begin : g_param_err
        $error("seg_scan_n: illegal parameter set");
    end

    function automatic logic [7:0] font(input logic [3:0] n);
        logic [7:0] f;
        unique case (n)
            4'h0: f = 8'h03;
            4'h1: f = 8'h9F;
            4'h2: f = 8'h25;
            4'h3: f = 8'h0D;
            4'h4: f = 8'h99;
            4'h5: f = 8'h49;
            4'h6: f = 8'h41;
            4'h7: f = 8'h1F;
            4'h8: f = 8'h01;
            4'h9: f = 8'h09;
            4'hA: f = 8'h11;
            4'hB: f = 8'hC1;
            4'hC: f = 8'h63;
            4'hD: f = 8'h85;
            4'hE: f = 8'h61;
            4'hF: f = 8'h71;
        endcase
        return f;
    endfunction

    // Scan counters
    logic [SW-1:0] slot_q, slot_d;
    logic [DW-1:0] dig_q, dig_d;
    logic          slot_end;
    logic          frame_end;

    assign slot_end  = (slot_q == SLOT_LAST);
    assign frame_end = slot_end && (dig_q == DIG_LAST);

    always_comb begin
        slot_d = slot_end ? '0 : slot_q + 1'b1;
        dig_d  = dig_q;
        if (slot_end) begin
            dig_d = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
        end
    end

    // Load path: pending register, transferred to shadow at frame end.
    logic [4*DIGITS-1:0] pval_q, pval_d;
    logic [DIGITS-1:0]   pdp_q, pdp_d;
    logic                pend_q, pend_d;
    logic [4*DIGITS-1:0] shv_q, shv_d;
    logic [DIGITS-1:0]   shdp_q, shdp_d;

    always_comb begin
        pval_d = pval_q;
        pdp_d  = pdp_q;
        pend_d = pend_q;
        shv_d  = shv_q;
        shdp_d = shdp_q;
        if (load_i) begin
            pval_d = value_i;
            pdp_d  = dp_i;
            pend_d = 1'b1;
        end
        // Using the _d values lets a frame-end load bypass straight to shadow.
        if (frame_end && pend_d) begin
            shv_d  = pval_d;
            shdp_d = pdp_d;
            pend_d = 1'b0;
        end
    end

`ifdef SEG_SCAN_BLINK_EN
    localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;

    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (frame_end) begin
            if (bcnt_q == BLINK_LAST) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end
`endif

    // Current digit selection and decode
    logic [3:0]        nib;
    logic              dig_dp;
    logic              dig_lz;
    logic              dig_blk;
    logic              upper_zero;
    logic [7:0]        seg_d;
    logic [DIGITS-1:0] sel_d;
    logic              dark;

    assign dark = (slot_q < BLANK_END);

    always_comb begin
        nib        = 4'h0;
        dig_dp     = 1'b0;
        dig_lz     = 1'b0;
        dig_blk    = 1'b0;
        upper_zero = 1'b1;
        sel_d      = '1;
        // Walk from the top digit down so upper_zero covers nibbles k..top.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            upper_zero = upper_zero && (shv_q[4*k +: 4] == 4'h0);
            if (dig_q == DW'(k)) begin
                nib      = shv_q[4*k +: 4];
                dig_dp   = shdp_q[k];
                dig_lz   = upper_zero && (k != 0);
                sel_d[k] = 1'b0;
`ifdef SEG_SCAN_BLINK_EN
                dig_blk  = ~phase_q & blink_mask_i[k];
`endif
            end
        end

        seg_d = (lz_blank_i && dig_lz) ? 8'hFF : font(nib);
        if (dig_dp) begin
            seg_d[0] = 1'b0;
        end
        if (dig_blk) begin
            seg_d = 8'hFF;
        end
        if (dark) begin
            seg_d = 8'hFF;
            sel_d = '1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            slot_q       <= '0;
            dig_q        <= '0;
            pval_q       <= '0;
            pdp_q        <= '0;
            pend_q       <= 1'b0;
            shv_q        <= '0;
            shdp_q       <= '0;
            seg_o        <= 8'hFF;
            sel_o        <= '1;
            frame_done_o <= 1'b0;
`ifdef SEG_SCAN_BLINK_EN
            bcnt_q       <= '0;
            phase_q      <= 1'b1;
`endif
        end else begin
            slot_q       <= slot_d;
            dig_q        <= dig_d;
            pval_q       <= pval_d;
            pdp_q        <= pdp_d;
            pend_q       <= pend_d;
            shv_q        <= shv_d;
            shdp_q       <= shdp_d;
            seg_o        <= seg_d;
            sel_o        <= sel_d;
            frame_done_o <= frame_end;
`ifdef SEG_SCAN_BLINK_EN
            bcnt_q       <= bcnt_d;
            phase_q      <= phase_d;
`endif
        end
    end

endmodule

// File: tb/tb_seg_scan_n.sv
// tb_seg_scan_n: scoreboard bench for seg_scan_n.
// Frame-level reference model feeds a queue; a negedge monitor compares.

module tb_seg_scan_n;

    localparam int DIGITS       = 4;
    localparam int SCAN_DIV     = 8;
    localparam int BLANK_CYCLES = 2;
    localparam int BLINK_FRAMES = 2;
    localparam int FRAME        = DIGITS * SCAN_DIV;

`ifdef SEG_SCAN_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    localparam logic [7:0] FONT [16] = '{
        8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
        8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71
    };

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] value_i = '0;
    logic [3:0]  dp_i = '0;
    logic        load_i = 1'b0;
    logic        lz_blank_i = 1'b0;
    logic [3:0]  blink_mask_i = '0;
    logic [7:0]  seg_o;
    logic [3:0]  sel_o;
    logic        frame_done_o;

    always #5 clk = ~clk;

    seg_scan_n #(
        .DIGITS      (DIGITS),
        .SCAN_DIV    (SCAN_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .value_i     (value_i),
        .dp_i        (dp_i),
        .load_i      (load_i),
        .lz_blank_i  (lz_blank_i),
`ifdef SEG_SCAN_BLINK_EN
        .blink_mask_i(blink_mask_i),
`endif
        .seg_o       (seg_o),
        .sel_o       (sel_o),
        .frame_done_o(frame_done_o)
    );

    typedef struct {
        logic [3:0] sel;
        logic [7:0] seg;
        logic       fd;
        int         c;
    } exp_t;

    exp_t q[$];

    int n_vec = 0;
    int n_bad = 0;
    bit mon_en = 1'b0;

    // Reference model state: what the display shows this frame,
    // plus the last load seen during the current frame.
    int          m_c = 0;
    logic [15:0] m_val = '0;
    logic [3:0]  m_dp = '0;
    logic        m_pend = 1'b0;
    logic [15:0] m_pval = '0;
    logic [3:0]  m_pdp = '0;

    task automatic check(input string name, input logic [7:0] act,
                         input logic [7:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %02h, required %02h", name, act, req);
        end
    endtask

    function automatic logic [7:0] digit_seg(input int k, input logic on);
        logic [7:0]  s;
        logic [15:0] upper;
        upper = m_val >> (4 * k);
        s = FONT[upper[3:0]];
        if (lz_blank_i && k > 0 && upper == 16'h0) s = 8'hFF;
        if (m_dp[k]) s[0] = 1'b0;
        if (BLINK && !on && blink_mask_i[k]) s = 8'hFF;
        return s;
    endfunction

    task automatic model_cycle(input logic ld, input logic [15:0] v,
                               input logic [3:0] d);
        exp_t e;
        int   slot;
        int   dig;
        int   frame;
        logic on;
        slot  = m_c % SCAN_DIV;
        dig   = (m_c / SCAN_DIV) % DIGITS;
        frame = m_c / FRAME;
        on    = ((frame / BLINK_FRAMES) % 2) == 0;
        e.c   = m_c;
        e.fd  = (m_c % FRAME) == FRAME - 1;
        if (slot < BLANK_CYCLES) begin
            e.sel = 4'hF;
            e.seg = 8'hFF;
        end else begin
            e.sel = ~(4'b0001 << dig);
            e.seg = digit_seg(dig, on);
        end
        q.push_back(e);
        if (ld) begin
            m_pend = 1'b1;
            m_pval = v;
            m_pdp  = d;
        end
        if (e.fd && m_pend) begin
            m_val  = m_pval;
            m_dp   = m_pdp;
            m_pend = 1'b0;
        end
        m_c++;
    endtask

    task automatic model_reset();
        m_c    = 0;
        m_val  = '0;
        m_dp   = '0;
        m_pend = 1'b0;
    endtask

    task automatic step(input logic ld, input logic [15:0] v,
                        input logic [3:0] d);
        load_i  = ld;
        value_i = ld ? v : 16'($urandom);
        dp_i    = ld ? d : 4'($urandom);
        model_cycle(ld, v, d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 16'h0, 4'h0);
    endtask

    task automatic goto_phase(input int p);
        while ((m_c % FRAME) != p) step(1'b0, 16'h0, 4'h0);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL underflow: got no expectation, required one");
            end else begin
                exp_t e;
                e = q.pop_front();
                check($sformatf("sel c=%0d", e.c), {4'h0, sel_o}, {4'h0, e.sel});
                check($sformatf("seg c=%0d", e.c), seg_o, e.seg);
                check($sformatf("frame_done c=%0d", e.c),
                      {7'h0, frame_done_o}, {7'h0, e.fd});
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset seg", seg_o, 8'hFF);
        check("reset sel", {4'h0, sel_o}, 8'h0F);
        check("reset frame_done", {7'h0, frame_done_o}, 8'h00);

        @(negedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;

        // Basic load and scan
        lz_blank_i = 1'b0;
        idle(3);
        step(1'b1, 16'h1234, 4'h0);
        goto_phase(0);
        idle(2 * FRAME);

        // Leading-zero blanking on then off
        step(1'b1, 16'h0050, 4'h0);
        lz_blank_i = 1'b1;
        goto_phase(0);
        idle(FRAME);
        lz_blank_i = 1'b0;
        idle(FRAME);

        // Blanked digit keeps its dp
        lz_blank_i = 1'b1;
        step(1'b1, 16'h0000, 4'b0100);
        goto_phase(0);
        idle(FRAME);

        // Anti-tearing: A then B five cycles later
        lz_blank_i = 1'b0;
        goto_phase(10);
        step(1'b1, 16'hABCD, 4'h3);
        idle(4);
        step(1'b1, 16'h5E6F, 4'h8);
        goto_phase(0);
        idle(FRAME);

        // Load on the frame-end cycle, alone and over a pending load
        goto_phase(FRAME - 1);
        step(1'b1, 16'h9876, 4'h1);
        idle(FRAME);
        goto_phase(20);
        step(1'b1, 16'h1111, 4'h2);
        goto_phase(FRAME - 1);
        step(1'b1, 16'h2222, 4'h4);
        idle(FRAME);

        // Randomised loads, dp and blanking
        repeat (10) begin
            lz_blank_i = 1'($urandom);
            repeat (FRAME) begin
                step($urandom_range(0, 15) == 0, 16'($urandom), 4'($urandom));
            end
        end

        // Blinking digit 0
        lz_blank_i   = 1'b0;
        blink_mask_i = 4'b0001;
        step(1'b1, 16'h8888, 4'h0);
        goto_phase(0);
        idle(6 * FRAME);
        blink_mask_i = 4'b0000;

        // Mid-slot reset with a pending load outstanding
        goto_phase(5);
        step(1'b1, 16'h7777, 4'hF);
        goto_phase(12);
        step(1'b0, 16'h0, 4'h0);
        check("pre-reset sel", {4'h0, sel_o}, 8'h0D);
        mon_en = 1'b0;
        q.delete();
        #1;
        reset_n = 1'b0;
        #1;
        check("async reset seg", seg_o, 8'hFF);
        check("async reset sel", {4'h0, sel_o}, 8'h0F);
        check("async reset frame_done", {7'h0, frame_done_o}, 8'h00);
        repeat (2) @(negedge clk);
        #1;
        reset_n = 1'b1;
        model_reset();
        mon_en = 1'b1;
        idle(2 * FRAME);

        load_i = 1'b0;
        @(negedge clk);
        #1;
        mon_en = 1'b0;
        check("drain", 8'(q.size()), 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
